audio_mix_engine: RTL

AUDIO_MIX_ENGINE -- requirements
Module: audio_mix_engine

---
 rtl/audio_mix_pkg.sv | 29 ++
 rtl/audio_mix_if.sv | 35 +++
 rtl/audio_sat.sv | 39 +++
 rtl/audio_mix_engine.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/audio_mix_pkg.sv
// rtl/audio_mix_pkg.sv - shared state type and width helpers for the audio mix engine
package audio_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2,
    HOLD  = 2'd3
  } mix_state_t;

  localparam int DEF_NUM_CH = 6;
  localparam int DEF_IN_W   = 16;
  localparam int DEF_VOL_W  = 4;
  localparam int DEF_OUT_W  = 24;

  // Sum of NUM_CH full-scale products plus one guard bit keeps the accumulator from wrapping.
  function automatic int acc_width(input int in_w, input int vol_w, input int num_ch);
    return in_w + vol_w + $clog2(num_ch) + 1;
  endfunction

  function automatic int idx_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int sat_in_width(input int acc_w, input int vol_w);
    return acc_w - vol_w;
  endfunction

endpackage

// File: rtl/audio_mix_if.sv
// rtl/audio_mix_if.sv - channel, control and result signals of the audio mix engine
interface audio_mix_if #(
  parameter int NUM_CH = 6,
  parameter int IN_W   = 16,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = 24
);

  logic [NUM_CH-1:0][IN_W-1:0]  ch_sample;
  logic [NUM_CH-1:0][VOL_W-1:0] ch_vol;
  logic [NUM_CH-1:0]            ch_en_l;
  logic [NUM_CH-1:0]            ch_en_r;
  logic                         master_en;
  logic                         sample_tick;
  logic [OUT_W-1:0]             out_l;
  logic [OUT_W-1:0]             out_r;
  logic                         out_valid;
  logic                         out_ready;
  logic                         busy;
  logic                         overrun;
  logic                         overrun_clr;

  modport master (
    output ch_sample, ch_vol, ch_en_l, ch_en_r, master_en, sample_tick,
    output out_ready, overrun_clr,
    input  out_l, out_r, out_valid, busy, overrun
  );

  modport slave (
    input  ch_sample, ch_vol, ch_en_l, ch_en_r, master_en, sample_tick,
    input  out_ready, overrun_clr,
    output out_l, out_r, out_valid, busy, overrun
  );

endinterface

// File: rtl/audio_sat.sv
// rtl/audio_sat.sv - drop volume fraction bits, clamp to input range, scale to output width
module audio_sat
  import audio_mix_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int IN_W  = 16,
  parameter int VOL_W = 4,
  parameter int OUT_W = 24
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    en,
  output logic signed [OUT_W-1:0] result
);

  localparam int SH_W = sat_in_width(ACC_W, VOL_W);

  localparam logic signed [SH_W-1:0] MAX_V = {{(SH_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [SH_W-1:0] MIN_V = {{(SH_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  logic signed [SH_W-1:0]  shifted;
  logic signed [IN_W-1:0]  clamped;
  logic signed [OUT_W-1:0] widened;

  // Dropping the low VOL_W bits of a signed vector is an arithmetic right shift.
  assign shifted = $signed(acc[ACC_W-1:VOL_W]);

  always_comb begin
    clamped = shifted[IN_W-1:0];
    if (shifted > MAX_V) begin
      clamped = MAX_V[IN_W-1:0];
    end else if (shifted < MIN_V) begin
      clamped = MIN_V[IN_W-1:0];
    end
  end

  assign widened = OUT_W'(clamped);
  assign result  = en ? (widened <<< (OUT_W - IN_W)) : '0;

endmodule

// File: rtl/audio_mix_engine.sv
// rtl/audio_mix_engine.sv - sequential per-channel stereo mixer with saturation and handshake
module audio_mix_engine
  import audio_mix_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IN_W   = DEF_IN_W,
  parameter int VOL_W  = DEF_VOL_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic        clk_100,
  input  logic        reset_n,
  audio_mix_if.slave  bus
);

  localparam int ACC_W  = acc_width(IN_W, VOL_W, NUM_CH);
  localparam int IDX_W  = idx_width(NUM_CH);
  localparam int PROD_W = IN_W + VOL_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  mix_state_t state, next_state;

  logic                         snap_take;
  logic                         acc_step;
  logic                         sat_load;
  logic                         ovr_set;

  logic [NUM_CH-1:0][IN_W-1:0]  snap_sample;
  logic [NUM_CH-1:0][VOL_W-1:0] snap_vol;
  logic [NUM_CH-1:0]            snap_en_l;
  logic [NUM_CH-1:0]            snap_en_r;
  logic                         snap_master;

  logic [IDX_W-1:0]             idx;
  logic signed [ACC_W-1:0]      acc_l;
  logic signed [ACC_W-1:0]      acc_r;
  logic signed [ACC_W-1:0]      prod_l;
  logic signed [ACC_W-1:0]      prod_r;
  logic signed [OUT_W-1:0]      sat_l;
  logic signed [OUT_W-1:0]      sat_r;
  logic [OUT_W-1:0]             out_l_q;
  logic [OUT_W-1:0]             out_r_q;
  logic                         overrun_q;

  // Signed sample times unsigned volume from an IN_W x VOL_W unsigned multiply:
  // a negative sample's raw bits exceed its value by 2^IN_W, so subtract vol << IN_W.
  function automatic logic signed [ACC_W-1:0] scaled(input logic [IN_W-1:0] s,
                                                     input logic [VOL_W-1:0] v);
    logic [PROD_W-1:0] mag;
    logic [ACC_W-1:0]  corr;
    mag  = PROD_W'(s) * PROD_W'(v);
    corr = s[IN_W-1] ? (ACC_W'(v) << IN_W) : '0;
    return $signed(ACC_W'(mag) - corr);
  endfunction

  assign prod_l = scaled(snap_en_l[idx] ? snap_sample[idx] : '0, snap_vol[idx]);
  assign prod_r = scaled(snap_en_r[idx] ? snap_sample[idx] : '0, snap_vol[idx]);

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    snap_take  = 1'b0;
    acc_step   = 1'b0;
    sat_load   = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_tick) begin
          snap_take  = 1'b1;
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        acc_step = 1'b1;
        ovr_set  = bus.sample_tick;
        if (idx == LAST_IDX) begin
          next_state = SAT;
        end
      end
      SAT: begin
        sat_load   = 1'b1;
        ovr_set    = bus.sample_tick;
        next_state = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          // Completing the handshake frees the engine in time to take this tick.
          if (bus.sample_tick) begin
            snap_take  = 1'b1;
            next_state = ACCUM;
          end else begin
            next_state = IDLE;
          end
        end else begin
          ovr_set = bus.sample_tick;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      snap_sample <= '0;
      snap_vol    <= '0;
      snap_en_l   <= '0;
      snap_en_r   <= '0;
      snap_master <= 1'b0;
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
    end else begin
      if (snap_take) begin
        snap_sample <= bus.ch_sample;
        snap_vol    <= bus.ch_vol;
        snap_en_l   <= bus.ch_en_l;
        snap_en_r   <= bus.ch_en_r;
        snap_master <= bus.master_en;
        idx         <= '0;
        acc_l       <= '0;
        acc_r       <= '0;
      end
      if (acc_step) begin
        acc_l <= acc_l + prod_l;
        acc_r <= acc_r + prod_r;
        idx   <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (sat_load) begin
        out_l_q <= sat_l;
        out_r_q <= sat_r;
      end
    end
  end

  // A dropped tick outranks a clear in the same cycle.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (ovr_set) begin
      overrun_q <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  audio_sat #(
    .ACC_W (ACC_W),
    .IN_W  (IN_W),
    .VOL_W (VOL_W),
    .OUT_W (OUT_W)
  ) u_sat_l (
    .acc    (acc_l),
    .en     (snap_master),
    .result (sat_l)
  );

  audio_sat #(
    .ACC_W (ACC_W),
    .IN_W  (IN_W),
    .VOL_W (VOL_W),
    .OUT_W (OUT_W)
  ) u_sat_r (
    .acc    (acc_r),
    .en     (snap_master),
    .result (sat_r)
  );

  assign bus.out_l     = out_l_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
  assign bus.overrun   = overrun_q;

endmodule
